// File: rtl/execute_port_wbuf.sv
// execute_port_wbuf: in-order writeback buffer between an ALU execute port's
// result mux and the scheduler commit (sche1) and writeback (sche2) paths.
//
// Ports:
//   iCLOCK, iRESET_SYNC        clock, synchronous active-high reset
//   iFREE_EX                   synchronous flush, empties the buffer
//   iPREV_*                    incoming ALU result fields, qualified by iPREV_VALID
//   oPREV_LOCK                 buffer full; upstream must hold its result
//   iNEXT_LOCK                 schedulers stalled; head entry is not popped
//   oSCHE1_VALID/COMMIT_TAG    head entry on the commit path
//   oSCHE2_*                   head entry fields on the writeback path
//   oCOUNT                     current occupancy
//   oERR_OVERFLOW              sticky: valid result offered while full
//
// A result accepted at one edge is visible on the head outputs in the next
// cycle when the buffer was empty. Head fields read as zero when empty.
module execute_port_wbuf #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned REGNAME_W = 6,
  parameter int unsigned FLAGREG_W = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic                 iFREE_EX,
  input  logic                 iPREV_VALID,
  input  logic [TAG_W-1:0]     iPREV_COMMIT_TAG,
  input  logic                 iPREV_SYSREG,
  input  logic [4:0]           iPREV_LOGIC_DEST,
  input  logic [REGNAME_W-1:0] iPREV_DESTINATION_REGNAME,
  input  logic                 iPREV_WRITEBACK,
  input  logic [DATA_W-1:0]    iPREV_DATA,
  input  logic [4:0]           iPREV_FLAG,
  input  logic                 iPREV_FLAGS_WRITEBACK,
  input  logic [FLAGREG_W-1:0] iPREV_FLAGS_REGNAME,
  output logic                 oPREV_LOCK,
  input  logic                 iNEXT_LOCK,
  output logic                 oSCHE1_VALID,
  output logic [TAG_W-1:0]     oSCHE1_COMMIT_TAG,
  output logic                 oSCHE2_VALID,
  output logic [TAG_W-1:0]     oSCHE2_COMMIT_TAG,
  output logic                 oSCHE2_SYSREG,
  output logic [4:0]           oSCHE2_LOGIC_DEST,
  output logic [REGNAME_W-1:0] oSCHE2_DESTINATION_REGNAME,
  output logic                 oSCHE2_WRITEBACK,
  output logic [DATA_W-1:0]    oSCHE2_DATA,
  output logic [4:0]           oSCHE2_FLAG,
  output logic                 oSCHE2_FLAGS_WRITEBACK,
  output logic [FLAGREG_W-1:0] oSCHE2_FLAGS_REGNAME,
  output logic [CNT_W-1:0]     oCOUNT,
  output logic                 oERR_OVERFLOW
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic                 sysreg;
    logic [4:0]           logic_dest;
    logic [REGNAME_W-1:0] regname;
    logic                 writeback;
    logic [DATA_W-1:0]    data;
    logic [4:0]           flag;
    logic                 flags_writeback;
    logic [FLAGREG_W-1:0] flags_regname;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] cnt;
  logic             overflow;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Full is taken from the registered count only, so a pop in the same cycle
  // never admits a push and iNEXT_LOCK has no path to oPREV_LOCK.
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign push  = iPREV_VALID && !full;
  assign pop   = !empty && !iNEXT_LOCK;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_entry = '{
    tag:             iPREV_COMMIT_TAG,
    sysreg:          iPREV_SYSREG,
    logic_dest:      iPREV_LOGIC_DEST,
    regname:         iPREV_DESTINATION_REGNAME,
    writeback:       iPREV_WRITEBACK,
    data:            iPREV_DATA,
    flag:            iPREV_FLAG,
    flags_writeback: iPREV_FLAGS_WRITEBACK,
    flags_regname:   iPREV_FLAGS_REGNAME
  };

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (iFREE_EX) begin
      // Flush discards the current input too and leaves the error flag alone.
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (iPREV_VALID && full) overflow <= 1'b1;
      if (push) wp <= wrap_inc(wp);
      if (pop)  rp <= wrap_inc(rp);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; emptiness is tracked by cnt alone.
  always_ff @(posedge iCLOCK) begin
    if (!iRESET_SYNC && !iFREE_EX && push) mem[wp] <= in_entry;
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem[rp];
  end

  assign oPREV_LOCK                 = full;
  assign oSCHE1_VALID               = !empty;
  assign oSCHE1_COMMIT_TAG          = head.tag;
  assign oSCHE2_VALID               = !empty;
  assign oSCHE2_COMMIT_TAG          = head.tag;
  assign oSCHE2_SYSREG              = head.sysreg;
  assign oSCHE2_LOGIC_DEST          = head.logic_dest;
  assign oSCHE2_DESTINATION_REGNAME = head.regname;
  assign oSCHE2_WRITEBACK           = head.writeback;
  assign oSCHE2_DATA                = head.data;
  assign oSCHE2_FLAG                = head.flag;
  assign oSCHE2_FLAGS_WRITEBACK     = head.flags_writeback;
  assign oSCHE2_FLAGS_REGNAME       = head.flags_regname;
  assign oCOUNT                     = cnt;
  assign oERR_OVERFLOW              = overflow;

endmodule

// File: tb/tb_execute_port_wbuf.sv
// Self-checking bench for execute_port_wbuf: a DEPTH=4 and a DEPTH=3 instance
// share one stimulus stream and are compared against queue-based models.
module tb_execute_port_wbuf;

  typedef struct packed {
    logic [5:0]  tag;
    logic        sysreg;
    logic [4:0]  ldest;
    logic [5:0]  rn;
    logic        wb;
    logic [31:0] data;
    logic [4:0]  flag;
    logic        fwb;
    logic [3:0]  frn;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, vld, nlock;
  ent_t cur;

  logic        lock_a, v1_a, v2_a, sys_a, wb_a, fwb_a, ovf_a;
  logic [5:0]  tag1_a, tag_a, rn_a;
  logic [4:0]  ld_a, fl_a;
  logic [31:0] dat_a;
  logic [3:0]  frn_a;
  logic [2:0]  cnt_a;

  logic        lock_b, v1_b, v2_b, sys_b, wb_b, fwb_b, ovf_b;
  logic [5:0]  tag1_b, tag_b, rn_b;
  logic [4:0]  ld_b, fl_b;
  logic [31:0] dat_b;
  logic [3:0]  frn_b;
  logic [1:0]  cnt_b;

  logic [73:0] obs_a, obs_b;
  assign obs_a = {lock_a, v1_a, tag1_a, v2_a, tag_a, sys_a, ld_a, rn_a, wb_a,
                  dat_a, fl_a, fwb_a, frn_a, cnt_a, ovf_a};
  assign obs_b = {lock_b, v1_b, tag1_b, v2_b, tag_b, sys_b, ld_b, rn_b, wb_b,
                  dat_b, fl_b, fwb_b, frn_b, 1'b0, cnt_b, ovf_b};

  execute_port_wbuf #(.DEPTH(4)) dut_a (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFREE_EX(flush), .iPREV_VALID(vld),
    .iPREV_COMMIT_TAG(cur.tag), .iPREV_SYSREG(cur.sysreg), .iPREV_LOGIC_DEST(cur.ldest),
    .iPREV_DESTINATION_REGNAME(cur.rn), .iPREV_WRITEBACK(cur.wb), .iPREV_DATA(cur.data),
    .iPREV_FLAG(cur.flag), .iPREV_FLAGS_WRITEBACK(cur.fwb), .iPREV_FLAGS_REGNAME(cur.frn),
    .oPREV_LOCK(lock_a), .iNEXT_LOCK(nlock), .oSCHE1_VALID(v1_a), .oSCHE1_COMMIT_TAG(tag1_a),
    .oSCHE2_VALID(v2_a), .oSCHE2_COMMIT_TAG(tag_a), .oSCHE2_SYSREG(sys_a),
    .oSCHE2_LOGIC_DEST(ld_a), .oSCHE2_DESTINATION_REGNAME(rn_a), .oSCHE2_WRITEBACK(wb_a),
    .oSCHE2_DATA(dat_a), .oSCHE2_FLAG(fl_a), .oSCHE2_FLAGS_WRITEBACK(fwb_a),
    .oSCHE2_FLAGS_REGNAME(frn_a), .oCOUNT(cnt_a), .oERR_OVERFLOW(ovf_a)
  );

  execute_port_wbuf #(.DEPTH(3)) dut_b (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFREE_EX(flush), .iPREV_VALID(vld),
    .iPREV_COMMIT_TAG(cur.tag), .iPREV_SYSREG(cur.sysreg), .iPREV_LOGIC_DEST(cur.ldest),
    .iPREV_DESTINATION_REGNAME(cur.rn), .iPREV_WRITEBACK(cur.wb), .iPREV_DATA(cur.data),
    .iPREV_FLAG(cur.flag), .iPREV_FLAGS_WRITEBACK(cur.fwb), .iPREV_FLAGS_REGNAME(cur.frn),
    .oPREV_LOCK(lock_b), .iNEXT_LOCK(nlock), .oSCHE1_VALID(v1_b), .oSCHE1_COMMIT_TAG(tag1_b),
    .oSCHE2_VALID(v2_b), .oSCHE2_COMMIT_TAG(tag_b), .oSCHE2_SYSREG(sys_b),
    .oSCHE2_LOGIC_DEST(ld_b), .oSCHE2_DESTINATION_REGNAME(rn_b), .oSCHE2_WRITEBACK(wb_b),
    .oSCHE2_DATA(dat_b), .oSCHE2_FLAG(fl_b), .oSCHE2_FLAGS_WRITEBACK(fwb_b),
    .oSCHE2_FLAGS_REGNAME(frn_b), .oCOUNT(cnt_b), .oERR_OVERFLOW(ovf_b)
  );

  // Reference model: one queue per instance plus a sticky overflow bit.
  ent_t qa[$];
  ent_t qb[$];
  bit   ova, ovb;
  int   vectors, miscompares;

  function automatic logic [73:0] view(input ent_t q[$], input int depth, input bit ovf);
    ent_t h;
    bit   ne;
    h  = '0;
    ne = (q.size() != 0);
    if (ne) h = q[0];
    return {q.size() == depth, ne, h.tag, ne, h, 3'(q.size()), ovf};
  endfunction

  function automatic ent_t rand_ent();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[60:0];
  endfunction

  // Advance one clock: the model applies the same cycle's inputs, then
  // outputs are sampled 1 time unit after the edge.
  task automatic step();
    bit fa, fb;
    @(posedge clk);
    fa = (qa.size() == 4);
    fb = (qb.size() == 3);
    if (rst) begin
      qa.delete(); qb.delete(); ova = 0; ovb = 0;
    end else if (flush) begin
      qa.delete(); qb.delete();
    end else begin
      if (vld && fa) ova = 1;
      if (vld && fb) ovb = 1;
      if (qa.size() != 0 && !nlock) void'(qa.pop_front());
      if (qb.size() != 0 && !nlock) void'(qb.pop_front());
      if (vld && !fa) qa.push_back(cur);
      if (vld && !fb) qb.push_back(cur);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; nlock = 0; vld = 1; cur = rand_ent();
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (obs_a !== 74'd0 || obs_b !== 74'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: a=%h b=%h expected all zero", obs_a, obs_b);
      end
    end
    rst = 0; vld = 0;
    step();
    vectors++;
    if (cnt_a !== 3'd0 || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", obs_a, view(qa, 4, ova));
    end
  endtask

  task automatic test_latency();
    cur = rand_ent(); cur.tag = 6'h15; cur.data = 32'hDEADBEEF;
    vld = 1; nlock = 0;
    step();
    vld = 0;
    vectors++;
    if (v1_a !== 1'b1 || v2_a !== 1'b1 || tag1_a !== 6'h15 || tag_a !== 6'h15 ||
        dat_a !== 32'hDEADBEEF || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL latency_head: got %h expected %h", obs_a, view(qa, 4, ova));
    end
    step();
    vectors++;
    if (v1_a !== 1'b0 || dat_a !== 32'd0 || obs_a !== 74'd0) begin
      miscompares++;
      $display("FAIL latency_drain: got %h expected 0", obs_a);
    end
  endtask

  task automatic test_fill();
    nlock = 1;
    for (int i = 1; i <= 5; i++) begin
      cur = rand_ent(); cur.tag = 6'(i); vld = 1;
      step();
      vectors++;
      if (obs_a !== view(qa, 4, ova)) begin
        miscompares++;
        $display("FAIL fill_push%0d: got %h expected %h", i, obs_a, view(qa, 4, ova));
      end
      if (i == 4) begin
        vectors++;
        if (lock_a !== 1'b1 || ovf_a !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_lock: lock=%b ovf=%b expected lock=1 ovf=0", lock_a, ovf_a);
        end
      end
    end
    vectors++;
    if (ovf_a !== 1'b1 || cnt_a !== 3'd4 || tag1_a !== 6'd1) begin
      miscompares++;
      $display("FAIL fill_overflow: ovf=%b cnt=%0d tag=%0d expected 1/4/1", ovf_a, cnt_a, tag1_a);
    end
    vld = 0; nlock = 0;
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (v1_a !== 1'b1 || tag1_a !== 6'(k)) begin
        miscompares++;
        $display("FAIL drain_order: valid=%b tag=%0d expected tag %0d", v1_a, tag1_a, k);
      end
      step();
    end
    vectors++;
    if (obs_a !== view(qa, 4, ova) || v1_a !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: got %h expected %h", obs_a, view(qa, 4, ova));
    end
  endtask

  task automatic test_full_pop();
    nlock = 1;
    for (int i = 0; i < 4; i++) begin
      cur = rand_ent(); cur.tag = 6'(20 + i); vld = 1;
      step();
    end
    // Pop while full: the offered input must be dropped.
    cur = rand_ent(); cur.tag = 6'h3F; vld = 1; nlock = 0;
    step();
    vectors++;
    if (cnt_a !== 3'd3 || tag1_a !== 6'd21 || lock_a !== 1'b0 || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL full_pop: got %h expected %h", obs_a, view(qa, 4, ova));
    end
    cur = rand_ent(); cur.tag = 6'd30; vld = 1; nlock = 1;
    step();
    vectors++;
    if (cnt_a !== 3'd4 || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL refill: got %h expected %h", obs_a, view(qa, 4, ova));
    end
    vld = 0; nlock = 0;
    step();
    // Push and pop together at cnt==3 and cnt==1: count holds.
    cur = rand_ent(); cur.tag = 6'd31; vld = 1;
    step();
    vectors++;
    if (cnt_a !== 3'd3 || tag1_a !== 6'd23 || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL pushpop_3: got %h expected %h", obs_a, view(qa, 4, ova));
    end
    vld = 0;
    step(); step();
    cur = rand_ent(); cur.tag = 6'd32; vld = 1;
    step();
    vld = 0;
    vectors++;
    if (cnt_a !== 3'd1 || tag1_a !== 6'd32 || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL pushpop_1: got %h expected %h", obs_a, view(qa, 4, ova));
    end
    step();
  endtask

  task automatic test_flush();
    rst = 1; vld = 0;
    step();
    rst = 0; nlock = 1;
    for (int i = 0; i < 4; i++) begin
      cur = rand_ent(); vld = 1;
      step();
    end
    // Flush while full with a valid input: no overflow.
    flush = 1; vld = 1; cur = rand_ent();
    step();
    flush = 0; vld = 0;
    vectors++;
    if (cnt_a !== 3'd0 || v1_a !== 1'b0 || ovf_a !== 1'b0 || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL flush_full: got %h expected %h", obs_a, view(qa, 4, ova));
    end
    for (int i = 0; i < 5; i++) begin
      cur = rand_ent(); vld = 1;
      step();
    end
    vld = 0; nlock = 0;
    step();
    nlock = 1; flush = 1; vld = 1; cur = rand_ent();
    step();
    flush = 0; vld = 0;
    vectors++;
    if (cnt_a !== 3'd0 || v1_a !== 1'b0 || ovf_a !== 1'b1 || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL flush_sticky: got %h expected %h", obs_a, view(qa, 4, ova));
    end
    cur = rand_ent(); cur.tag = 6'd7; vld = 1; nlock = 0;
    step();
    vld = 0;
    vectors++;
    if (v1_a !== 1'b1 || tag1_a !== 6'd7 || obs_a !== view(qa, 4, ova)) begin
      miscompares++;
      $display("FAIL flush_refill: got %h expected %h", obs_a, view(qa, 4, ova));
    end
    step();
  endtask

  task automatic test_wrap();
    int          sent;
    bit          acc;
    logic [5:0]  got[$];
    rst = 1; vld = 0; nlock = 0;
    step();
    rst = 0;
    sent = 0;
    for (int cyc = 0; cyc < 300 && (sent < 10 || qb.size() != 0); cyc++) begin
      nlock = ($urandom_range(0, 2) == 0);
      vld   = (sent < 10) && ($urandom_range(0, 3) != 0);
      cur   = rand_ent(); cur.tag = 6'(40 + sent);
      acc   = vld && (qb.size() < 3);
      if (v1_b === 1'b1 && !nlock) got.push_back(tag1_b);
      step();
      if (acc) sent++;
      vectors++;
      if (obs_b !== view(qb, 3, ovb)) begin
        miscompares++;
        $display("FAIL wrap_cycle%0d: got %h expected %h", cyc, obs_b, view(qb, 3, ovb));
      end
    end
    vld = 0;
    vectors++;
    if (got.size() != 10) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d entries expected 10", got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vectors++;
        if (got[i] !== 6'(40 + i)) begin
          miscompares++;
          $display("FAIL wrap_order%0d: got %0d expected %0d", i, got[i], 40 + i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rst = 1; vld = 0;
    step();
    rst = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      vld   = ($urandom_range(0, 9) < 7);
      nlock = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 49) == 0);
      cur   = rand_ent();
      step();
      vectors++;
      if (obs_a !== view(qa, 4, ova) || obs_b !== view(qb, 3, ovb)) begin
        miscompares++;
        $display("FAIL random_cycle%0d: a=%h exp %h b=%h exp %h", cyc, obs_a,
                 view(qa, 4, ova), obs_b, view(qb, 3, ovb));
      end
    end
    flush = 0; vld = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; ova = 0; ovb = 0;
    rst = 1; flush = 0; vld = 0; nlock = 0; cur = '0;
    #1;
    test_reset();
    test_latency();
    test_fill();
    test_full_pop();
    test_flush();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_port_wbuf.md
# execute_port_wbuf

Parametrised writeback buffer stage for the execute ports. It sits between an ALU execute port's result mux and the scheduler writeback/commit paths. It replaces the single always-ready b0 latch with a DEPTH-entry in-order FIFO. It adds real backpressure in both directions, flush, an overflow error flag and an occupancy output. ALU results enter with one cycle of latency and are presented to scheduler1 (commit) and scheduler2 (register/flag writeback) in arrival order.

## Interface
- DATA_W, 32, result data width
- TAG_W, 6, commit tag width
- REGNAME_W, 6, physical destination register name width
- FLAGREG_W, 4, flags register name width
- DEPTH, 4, FIFO entries (>= 1)
- CNT_W, $clog2(DEPTH+1), occupancy width
- iCLOCK  in  1  clock
- iRESET_SYNC  in  1  synchronous active-high reset
- iFREE_EX  in  1  pipeline flush, synchronous
- iPREV_VALID  in  1  result valid from ALU mux
- iPREV_COMMIT_TAG  in  TAG_W  commit tag
- iPREV_SYSREG  in  1  destination is system register
- iPREV_LOGIC_DEST  in  5  logical destination (debug)
- iPREV_DESTINATION_REGNAME  in  REGNAME_W  physical destination
- iPREV_WRITEBACK  in  1  register writeback enable
- iPREV_DATA  in  DATA_W  result data
- iPREV_FLAG  in  5  {SF,OF,CF,PF,ZF}
- iPREV_FLAGS_WRITEBACK  in  1  flag writeback enable
- iPREV_FLAGS_REGNAME  in  FLAGREG_W  flags register name
- oPREV_LOCK  out  1  buffer full, upstream must hold
- iNEXT_LOCK  in  1  schedulers stall, head must not pop
- oSCHE1_VALID  out  1  head valid (commit path)
- oSCHE1_COMMIT_TAG  out  TAG_W  head tag
- oSCHE2_VALID  out  1  head valid (writeback path)
- oSCHE2_COMMIT_TAG, oSCHE2_SYSREG, oSCHE2_LOGIC_DEST, oSCHE2_DESTINATION_REGNAME, oSCHE2_WRITEBACK, oSCHE2_DATA, oSCHE2_FLAG, oSCHE2_FLAGS_WRITEBACK, oSCHE2_FLAGS_REGNAME  out  as inputs  head entry fields
- oCOUNT  out  CNT_W  current occupancy
- oERR_OVERFLOW  out  1  sticky: valid presented while locked

## Operation
- Storage: DEPTH entries holding all iPREV_* fields, with write pointer wp, read pointer rp and count cnt.
- Pointers wrap from DEPTH-1 to 0. DEPTH=1 is a single register.
- oPREV_LOCK = (cnt == DEPTH). It is driven from registered count, so there is no combinational path from iNEXT_LOCK.
- push = iPREV_VALID && !oPREV_LOCK. pop = (cnt != 0) && !iNEXT_LOCK.
- Simultaneous push and pop: both occur and cnt is unchanged. This also applies at cnt==DEPTH-1 and cnt==1.
- No push is accepted when full, even if a pop occurs in the same cycle. Lock releases one cycle after the pop.
- iPREV_VALID && oPREV_LOCK: the input is dropped, the FIFO is unchanged and oERR_OVERFLOW sets. It clears only on reset; iFREE_EX does not clear it.
- Head outputs:
  - When cnt != 0, every oSCHE2_* field and oSCHE1_COMMIT_TAG shows entry[rp], and oSCHE1_VALID = oSCHE2_VALID = 1.
  - When cnt == 0, both valids are 0 and all data fields are forced to 0.
- iFREE_EX has priority over push/pop. Next cycle: cnt=0, wp=rp=0, outputs zero. Input presented in the flush cycle is discarded and does not raise overflow.
- iRESET_SYNC has priority over iFREE_EX. Next cycle: all outputs 0, oERR_OVERFLOW=0, pointers and count 0. Entry contents need not be cleared.

## Timing
- Latency: an input accepted at edge N into an empty buffer is visible on outputs after edge N, i.e. in cycle N+1. This matches the former single-latch port.
- Throughput: 1 entry/cycle sustained while iNEXT_LOCK=0.
- Back-to-back entries drain in order, one per cycle. A head stalled by iNEXT_LOCK holds all output fields stable.
- Reset values: all outputs 0, including oPREV_LOCK=0 and oCOUNT=0.

## Test plan
- Reset: hold iRESET_SYNC 2 cycles with iPREV_VALID=1 -> all outputs 0, and oCOUNT=0 after release.
- Latency: DEPTH=4, one push with tag 6'h15 and data 32'hDEADBEEF, iNEXT_LOCK=0 -> next cycle valids=1 with those values, then valids=0 and outputs zero.
- Fill/stall: iNEXT_LOCK=1, push tags 1..5 on consecutive cycles ->
  - tags 1–4 stored, oPREV_LOCK=1 after the 4th push, tag 5 dropped and oERR_OVERFLOW=1.
  - Release the lock -> tags 1,2,3,4 appear on consecutive cycles.
- Simultaneous push/pop at full: cnt=4, pop with iPREV_VALID=1 -> input dropped, cnt=3. The next push is accepted and cnt returns to 4.
- Flush: cnt=3, iFREE_EX=1 with iPREV_VALID=1 -> next cycle cnt=0, valids 0, oERR_OVERFLOW unchanged. A following push appears after 1 cycle at slot 0.
- Wrap: DEPTH=3, stream 10 entries with random iNEXT_LOCK -> the output tag sequence equals the input sequence, with no loss or duplication.
